// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/interlock control in front of the multiply/divide unit.
// Fires a one-cycle start for mult/multu/div/divu sitting in EX. It tracks the
// unit through ARMED (start sent, busy not yet seen) and RUN (busy high). It
// stalls D while a HI/LO-class instruction could observe stale HI/LO, and it
// muxes HI/LO onto the EX writeback path for mfhi/mflo.
module md_issue_ctrl #(
  parameter int ARM_TIMEOUT = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrD,
  input  logic [31:0]      instrE,
  input  logic             validE,
  input  logic             flushE,
  input  logic             busy,
  input  logic [31:0]      hdata,
  input  logic [31:0]      ldata,
  output logic             start,
  output logic             stallD,
  output logic [31:0]      mdoutE,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam int TW = (ARM_TIMEOUT < 2) ? 1 : $clog2(ARM_TIMEOUT + 1);
  localparam logic [TW-1:0] ARM_LAST = TW'(ARM_TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] arm_tmr;

  // mult, multu, div, divu: the ops that kick the unit
  function automatic logic is_muldiv(input logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:2] == 4'b0110);
  endfunction

  // the four ops above plus mfhi/mthi/mflo/mtlo
  function automatic logic is_md(input logic [31:0] i);
    return (i[31:26] == 6'd0) && ((i[5:2] == 4'b0110) || (i[5:2] == 4'b0100));
  endfunction

  // Issue and interlock. A stale busy in IDLE holds off the start. The
  // busy-falling RUN cycle does not stall because HI/LO are already valid.
  always_comb begin
    start  = (state == IDLE) && !busy && validE && !flushE && is_muldiv(instrE);
    stallD = is_md(instrD) && (start || (state == ARMED) || busy);
  end

  // HI/LO read path for mfhi/mflo in EX; zero for everything else
  always_comb begin
    mdoutE = 32'd0;
    if (instrE[31:26] == 6'd0) begin
      case (instrE[5:0])
        6'h10:   mdoutE = hdata;
        6'h12:   mdoutE = ldata;
        default: mdoutE = 32'd0;
      endcase
    end
  end

  // Unit tracking. If busy never shows up, the op is abandoned and err sticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      arm_tmr <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          arm_tmr <= '0;
          if (start) state <= ARMED;
        end
        ARMED: begin
          if (busy) begin
            state   <= RUN;
            arm_tmr <= '0;
          end else if (arm_tmr == ARM_LAST) begin
            state   <= IDLE;
            arm_tmr <= '0;
            err     <= 1'b1;
          end else begin
            arm_tmr <= arm_tmr + 1'b1;
          end
        end
        RUN: begin
          if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Performance counter of stalled cycles; wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (stallD) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
